ram_pattern_gen: RTL and testbench
==================================

# ram_pattern_gen

Pattern generator and sequencer for the 32 x 8 RAM test path. On a start request it fills every RAM location with a deterministic incrementing pattern, waits a programmable gap, then sweeps the RAM read port across all locations so the downstream data checker can compare read data against the expected sequence. It sits between the test-control logic and the RAM, driving both RAM ports, and is the write-side counterpart of the RAM data checker.

## Interface
- ADDR_W, 5, RAM address width; the sweep covers 2^ADDR_W locations (32).
- DATA_W, 8, RAM data width.
- SEED, 0, pattern value written to address 0.
- GAP_CYCLES, 2, idle cycles between the last write and the first read; 0..15 legal.

- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  request to run one write/read sequence; sampled only in IDLE.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse when the read sweep completes.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  ADDR_W  RAM write address.
- ram_wr_data  output  DATA_W  RAM write data.
- ram_rd_en  output  1  RAM read enable; also feeds the data checker.
- ram_rd_addr  output  ADDR_W  RAM read address; also feeds the data checker.

## Operation
- FSM states: IDLE, WRITE, GAP, READ, DONE.
- IDLE: all enables low; start=1 -> WRITE, address counter cleared to 0.
- WRITE: ram_wr_en=1, ram_wr_addr = counter, ram_wr_data = (SEED + counter) mod 2^DATA_W; counter increments each cycle; after address 2^ADDR_W-1 -> GAP (or READ if GAP_CYCLES=0), counter cleared.
- GAP: all enables low; gap counter counts GAP_CYCLES cycles, then -> READ.
- READ: ram_rd_en=1, ram_rd_addr = counter, incrementing each cycle; after address 2^ADDR_W-1 -> DONE.
- DONE: done=1 for exactly one cycle, all enables low -> IDLE.
- Data arithmetic truncates to DATA_W bits (SEED=250 gives 250..255, 0..25).
- start while not IDLE is ignored; no queuing.
- Write and read enables are never high in the same cycle.
- All outputs registered; no combinational path from start to any output.

## Timing
- Reset values: busy=0, done=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_en=0, ram_rd_addr=0; state IDLE.
- start high at edge N (in IDLE) -> ram_wr_en=1, addr 0 from edge N+1; 32 consecutive write cycles N+1..N+32.
- Gap cycles N+33..N+32+GAP_CYCLES; reads N+33+GAP_CYCLES .. N+64+GAP_CYCLES; done at N+65+GAP_CYCLES.
- busy high from N+1 through the last read cycle; low in the done cycle.
- Back-to-back: start held high is re-sampled in the IDLE cycle after DONE; next sequence begins one cycle later.
- Address/data outputs hold their last value when their enable is low; they are don't-care to consumers then.
- rstn asserted mid-sequence: all outputs return to reset values immediately; FSM to IDLE; a new start is required after release.

## Configuration
- RAM_GEN_AUTO_START_EN defined: one sequence starts automatically on the first clock edge after rstn deasserts, as if start were pulsed; later sequences still need start.
- Undefined: the block stays in IDLE after reset until start is sampled high.

## Test plan
- Defaults, start pulse one cycle -> writes addr 0..31 data 0..31 on 32 cycles, 2 gap cycles, reads addr 0..31, done pulse 67 cycles after start edge; checker ram_data_error=0.
- SEED=250 -> write data 250..255 at addr 0..5, 0 at addr 6, 25 at addr 31.
- GAP_CYCLES=0 -> first read cycle immediately follows write to addr 31; done 65 cycles after start.
- start pulsed during WRITE and READ -> ignored; exactly one sequence, one done pulse.
- rstn low at write addr 10 -> all outputs 0 asynchronously; after release, no activity until start; next run writes from addr 0.
- RAM_GEN_AUTO_START_EN defined, no start -> ram_wr_en=1 addr 0 one cycle after first post-reset edge; full sequence completes.

Source files
------------

// File: rtl/ram_pattern_gen_if.sv
// ram_pattern_gen_if: control handshake and RAM write/read port bundle for the
// RAM test-path pattern generator. master = generator side, slave = consumer side.
interface ram_pattern_gen_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);

  logic              start;
  logic              busy;
  logic              done;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;

  modport master (
    input  start,
    output busy,
    output done,
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output ram_rd_en,
    output ram_rd_addr
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    input  ram_rd_en,
    input  ram_rd_addr
  );

endinterface

// File: rtl/ram_pattern_gen.sv
// ram_pattern_gen: fills the RAM with an incrementing pattern starting at SEED,
// idles GAP_CYCLES cycles, then sweeps the read port over every location.
// Every output is a register fed from the current FSM state, so an output
// appears one cycle after the state it belongs to.
// Optional feature: define RAM_GEN_AUTO_START_EN to launch one sequence on the
// first clock edge after reset release without a start request.
module ram_pattern_gen #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEED       = 0,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  ram_pattern_gen_if.master  bus
);

  localparam int unsigned      GAP_W     = 4;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [GAP_W-1:0]  GAP_LAST  =
    GAP_W'((GAP_CYCLES == 0) ? 0 : (GAP_CYCLES - 1));
  localparam logic              HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [DATA_W-1:0] SEED_D    = DATA_W'(SEED);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_cnt_nxt;

  logic              start_req_c;
  logic              busy_c;
  logic              done_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] wr_data_c;

  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

`ifdef RAM_GEN_AUTO_START_EN
  logic auto_pend;

  // One-shot start request that is live only until the first edge after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) auto_pend <= 1'b1;
    else       auto_pend <= 1'b0;
  end

  assign start_req_c = bus.start | auto_pend;
`else
  assign start_req_c = bus.start;
`endif

  // State, address counter and gap counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Next-state logic and per-state output values (registered below)
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gap_cnt_nxt = gap_cnt;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    wr_data_c   = SEED_D + DATA_W'(cnt);

    unique case (state)
      IDLE: begin
        if (start_req_c) begin
          state_nxt = WRITE;
          cnt_nxt   = '0;
        end
      end

      WRITE: begin
        busy_c  = 1'b1;
        wr_en_c = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_LAST) begin
          cnt_nxt     = '0;
          gap_cnt_nxt = '0;
          state_nxt   = HAS_GAP ? GAP : READ;
        end
      end

      GAP: begin
        busy_c = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = READ;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      READ: begin
        busy_c  = 1'b1;
        rd_en_c = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end

      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output registers; address/data hold their last value while disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      busy  <= busy_c;
      done  <= done_c;
      wr_en <= wr_en_c;
      rd_en <= rd_en_c;
      if (wr_en_c) begin
        wr_addr <= cnt;
        wr_data <= wr_data_c;
      end
      if (rd_en_c) begin
        rd_addr <= cnt;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_wr_addr = wr_addr;
  assign bus.ram_wr_data = wr_data;
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_addr;

endmodule

// File: tb/tb_ram_pattern_gen.sv
// tb_ram_pattern_gen: directed table-driven bench for ram_pattern_gen.
// dut0: defaults; dut1: SEED=250; dut2: GAP_CYCLES=0. All share clk/rstn/start.
// k counts clock edges after the edge that sampled start (k=0 is that edge).
module tb_ram_pattern_gen;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  ram_pattern_gen_if #(.ADDR_W(5), .DATA_W(8)) bus0 ();
  ram_pattern_gen_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();
  ram_pattern_gen_if #(.ADDR_W(5), .DATA_W(8)) bus2 ();

  ram_pattern_gen #(.ADDR_W(5), .DATA_W(8), .SEED(0), .GAP_CYCLES(2)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0));
  ram_pattern_gen #(.ADDR_W(5), .DATA_W(8), .SEED(250), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1));
  ram_pattern_gen #(.ADDR_W(5), .DATA_W(8), .SEED(0), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rstn(rstn), .bus(bus2));

  typedef struct {
    int k;
    int w;    int r;   int b;   int d;     // dut0/dut1 enables, busy, done
    int wa;   int wd;  int ra;             // dut0 addresses and write data
    int sd;                                // dut1 write data (SEED=250)
    int g_w;  int g_r; int g_b; int g_d;   // dut2 (no gap)
    int g_ra;
  } vec_t;

  vec_t vecs[16];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt[3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    bus0.start = v;
    bus1.start = v;
    bus2.start = v;
  endtask

  // Advance one edge, sample just after it, track done pulses and enable exclusivity
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus0.done) done_cnt[0]++;
    if (bus1.done) done_cnt[1]++;
    if (bus2.done) done_cnt[2]++;
    chk("wr_rd_excl_dut0", int'(bus0.ram_wr_en & bus0.ram_rd_en), 0);
    chk("wr_rd_excl_dut2", int'(bus2.ram_wr_en & bus2.ram_rd_en), 0);
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (bus0.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_within_bound", int'(seen), 1);
  endtask

  task automatic post_reset_check();
`ifdef RAM_GEN_AUTO_START_EN
    tick();
    chk("auto_wr_en_first_edge", int'(bus0.ram_wr_en), 0);
    tick();
    chk("auto_wr_en", int'(bus0.ram_wr_en), 1);
    chk("auto_wr_addr", int'(bus0.ram_wr_addr), 0);
    wait_done(100);
    tick();
`else
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy", int'(bus0.busy), 0);
      chk("idle_wr_en", int'(bus0.ram_wr_en), 0);
    end
`endif
  endtask

  initial begin
    int k;

    //            k   w r b d  wa wd ra  sd  gw gr gb gd gra
    vecs[0]  = '{  0, 0,0,0,0,  0, 0, 0,   0, 0,0,0,0,  0};
    vecs[1]  = '{  1, 1,0,1,0,  0, 0, 0, 250, 1,0,1,0,  0};
    vecs[2]  = '{  2, 1,0,1,0,  1, 1, 0, 251, 1,0,1,0,  0};
    vecs[3]  = '{  6, 1,0,1,0,  5, 5, 0, 255, 1,0,1,0,  0};
    vecs[4]  = '{  7, 1,0,1,0,  6, 6, 0,   0, 1,0,1,0,  0};
    vecs[5]  = '{ 17, 1,0,1,0, 16,16, 0,  10, 1,0,1,0,  0};
    vecs[6]  = '{ 32, 1,0,1,0, 31,31, 0,  25, 1,0,1,0,  0};
    vecs[7]  = '{ 33, 0,0,1,0,  0, 0, 0,   0, 0,1,1,0,  0};
    vecs[8]  = '{ 34, 0,0,1,0,  0, 0, 0,   0, 0,1,1,0,  1};
    vecs[9]  = '{ 35, 0,1,1,0,  0, 0, 0,   0, 0,1,1,0,  2};
    vecs[10] = '{ 36, 0,1,1,0,  0, 0, 1,   0, 0,1,1,0,  3};
    vecs[11] = '{ 64, 0,1,1,0,  0, 0,29,   0, 0,1,1,0, 31};
    vecs[12] = '{ 65, 0,1,1,0,  0, 0,30,   0, 0,0,0,1,  0};
    vecs[13] = '{ 66, 0,1,1,0,  0, 0,31,   0, 0,0,0,0,  0};
    vecs[14] = '{ 67, 0,0,0,1,  0, 0, 0,   0, 0,0,0,0,  0};
    vecs[15] = '{ 68, 0,0,0,0,  0, 0, 0,   0, 0,0,0,0,  0};

    done_cnt = '{0, 0, 0};
    set_start(1'b0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_done", int'(bus0.done), 0);
    chk("rst_wr_en", int'(bus0.ram_wr_en), 0);
    chk("rst_wr_addr", int'(bus0.ram_wr_addr), 0);
    chk("rst_wr_data", int'(bus1.ram_wr_data), 0);
    chk("rst_rd_en", int'(bus0.ram_rd_en), 0);
    chk("rst_rd_addr", int'(bus0.ram_rd_addr), 0);
    rstn = 1'b1;
    post_reset_check();
    done_cnt = '{0, 0, 0};

    // Single sequence, with ignored start pulses in WRITE (edge 10) and READ (edge 40)
    set_start(1'b1);
    tick();
    set_start(1'b0);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      while (k < vecs[i].k) begin
        if (k == 9 || k == 39) set_start(1'b1);
        tick();
        set_start(1'b0);
        k++;
      end
      chk($sformatf("k%0d_wr_en", k), int'(bus0.ram_wr_en), vecs[i].w);
      chk($sformatf("k%0d_rd_en", k), int'(bus0.ram_rd_en), vecs[i].r);
      chk($sformatf("k%0d_busy", k), int'(bus0.busy), vecs[i].b);
      chk($sformatf("k%0d_done", k), int'(bus0.done), vecs[i].d);
      chk($sformatf("k%0d_s250_wr_en", k), int'(bus1.ram_wr_en), vecs[i].w);
      chk($sformatf("k%0d_s250_done", k), int'(bus1.done), vecs[i].d);
      if (vecs[i].w != 0) begin
        chk($sformatf("k%0d_wr_addr", k), int'(bus0.ram_wr_addr), vecs[i].wa);
        chk($sformatf("k%0d_wr_data", k), int'(bus0.ram_wr_data), vecs[i].wd);
        chk($sformatf("k%0d_s250_wr_data", k), int'(bus1.ram_wr_data), vecs[i].sd);
      end
      if (vecs[i].r != 0) begin
        chk($sformatf("k%0d_rd_addr", k), int'(bus0.ram_rd_addr), vecs[i].ra);
      end
      chk($sformatf("k%0d_g0_wr_en", k), int'(bus2.ram_wr_en), vecs[i].g_w);
      chk($sformatf("k%0d_g0_rd_en", k), int'(bus2.ram_rd_en), vecs[i].g_r);
      chk($sformatf("k%0d_g0_busy", k), int'(bus2.busy), vecs[i].g_b);
      chk($sformatf("k%0d_g0_done", k), int'(bus2.done), vecs[i].g_d);
      if (vecs[i].g_r != 0) begin
        chk($sformatf("k%0d_g0_rd_addr", k), int'(bus2.ram_rd_addr), vecs[i].g_ra);
      end
    end

    // No queued second sequence from the ignored pulses
    repeat (80) tick();
    chk("one_done_dut0", done_cnt[0], 1);
    chk("one_done_dut1", done_cnt[1], 1);
    chk("one_done_dut2", done_cnt[2], 1);
    chk("quiet_busy", int'(bus0.busy), 0);
    chk("quiet_wr_en", int'(bus0.ram_wr_en), 0);

    // Back-to-back: start held high restarts on the IDLE edge after DONE
    set_start(1'b1);
    tick();
    for (int j = 1; j <= 69; j++) begin
      tick();
      if (j == 67) chk("b2b_done", int'(bus0.done), 1);
      if (j == 68) chk("b2b_gap_wr_en", int'(bus0.ram_wr_en), 0);
      if (j == 69) begin
        chk("b2b_wr_en", int'(bus0.ram_wr_en), 1);
        chk("b2b_wr_addr", int'(bus0.ram_wr_addr), 0);
        chk("b2b_busy", int'(bus0.busy), 1);
      end
    end
    set_start(1'b0);
    wait_done(100);
    repeat (3) tick();

    // Asynchronous reset in the middle of the write phase
    set_start(1'b1);
    tick();
    set_start(1'b0);
    repeat (11) tick();
    chk("pre_rst_wr_en", int'(bus0.ram_wr_en), 1);
    chk("pre_rst_wr_addr", int'(bus0.ram_wr_addr), 10);
    rstn = 1'b0;
    #1;
    chk("arst_busy", int'(bus0.busy), 0);
    chk("arst_wr_en", int'(bus0.ram_wr_en), 0);
    chk("arst_wr_addr", int'(bus0.ram_wr_addr), 0);
    chk("arst_wr_data", int'(bus1.ram_wr_data), 0);
    chk("arst_rd_en", int'(bus0.ram_rd_en), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    post_reset_check();

    // Fresh run after reset restarts at address 0
    set_start(1'b1);
    tick();
    set_start(1'b0);
    tick();
    chk("rerun_wr_en", int'(bus0.ram_wr_en), 1);
    chk("rerun_wr_addr", int'(bus0.ram_wr_addr), 0);
    chk("rerun_wr_data", int'(bus0.ram_wr_data), 0);
    chk("rerun_s250_data", int'(bus1.ram_wr_data), 250);
    wait_done(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
